// File: rtl/demux_reg_bank.sv
// demux_reg_bank: distributes an 18-bit word into eleven output registers, either by Sel or by auto-fill.
// Optional macro DEMUX_SHADOW_EN: auto-fill lands in a shadow bank copied to the outputs when the frame completes.
module demux_reg_bank (
   input  logic        clk,
   input  logic        reset,
   input  logic [17:0] DatEnt,
   input  logic        WrEn,
   input  logic [3:0]  Sel,
   input  logic        AutoMode,
   input  logic        Start,
   output logic [17:0] Dat0,
   output logic [17:0] Dat1,
   output logic [17:0] Dat2,
   output logic [17:0] Dat3,
   output logic [17:0] Dat4,
   output logic [17:0] Dat5,
   output logic [17:0] Dat6,
   output logic [17:0] Dat7,
   output logic [17:0] Dat8,
   output logic [17:0] Dat9,
   output logic [17:0] Dat10,
   output logic [3:0]  WrIdx,
   output logic        Busy,
   output logic        FrameDone,
   output logic        SelErr
);
   localparam int         N_REG    = 11;
   localparam logic [3:0] LAST_IDX = 4'd10;

   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

   state_t      state_q;
   logic [3:0]  wr_idx_q;
   logic        busy_q;
   logic        frame_done_q;
   logic        sel_err_q;

   logic        manual_wr;
   logic        fill_wr;
   logic        fill_last;

   // Start inside FILL takes priority over WrEn, so a restart cycle never writes.
   assign manual_wr = (state_q == IDLE) && !AutoMode && WrEn;
   assign fill_wr   = (state_q == FILL) && WrEn && !Start;
   assign fill_last = fill_wr && (wr_idx_q == LAST_IDX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         wr_idx_q     <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         sel_err_q    <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         sel_err_q    <= manual_wr && (Sel > LAST_IDX);
         case (state_q)
            IDLE: begin
               if (AutoMode && Start) begin
                  state_q  <= FILL;
                  busy_q   <= 1'b1;
                  wr_idx_q <= '0;
               end
            end
            FILL: begin
               if (Start) begin
                  wr_idx_q <= '0;
               end else if (WrEn) begin
                  if (wr_idx_q == LAST_IDX) begin
                     state_q      <= IDLE;
                     busy_q       <= 1'b0;
                     wr_idx_q     <= '0;
                     frame_done_q <= 1'b1;
                  end else begin
                     wr_idx_q <= wr_idx_q + 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic [17:0] dat_w [N_REG];

   for (genvar gi = 0; gi < N_REG; gi++) begin : g_bank
      localparam logic [3:0] IDX = 4'(gi);
      logic [17:0] dat_q;
      logic [17:0] dat_d;
      logic        manual_hit;
      logic        fill_hit;

      // An illegal Sel can never equal a bank index, so no extra range check is needed here.
      assign manual_hit = manual_wr && (Sel == IDX);
      assign fill_hit   = fill_wr && (wr_idx_q == IDX);

`ifdef DEMUX_SHADOW_EN
      logic [17:0] shadow_q;
      logic [17:0] shadow_d;

      always_comb begin
         shadow_d = shadow_q;
         if (manual_hit || fill_hit) shadow_d = DatEnt;
         dat_d = dat_q;
         if (manual_hit) dat_d = DatEnt;
         else if (fill_last) dat_d = shadow_d;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) shadow_q <= '0;
         else       shadow_q <= shadow_d;
      end
`else
      always_comb begin
         dat_d = dat_q;
         if (manual_hit || fill_hit) dat_d = DatEnt;
      end
`endif

      always_ff @(posedge clk or posedge reset) begin
         if (reset) dat_q <= '0;
         else       dat_q <= dat_d;
      end

      assign dat_w[gi] = dat_q;
   end

   assign Dat0      = dat_w[0];
   assign Dat1      = dat_w[1];
   assign Dat2      = dat_w[2];
   assign Dat3      = dat_w[3];
   assign Dat4      = dat_w[4];
   assign Dat5      = dat_w[5];
   assign Dat6      = dat_w[6];
   assign Dat7      = dat_w[7];
   assign Dat8      = dat_w[8];
   assign Dat9      = dat_w[9];
   assign Dat10     = dat_w[10];
   assign WrIdx     = wr_idx_q;
   assign Busy      = busy_q;
   assign FrameDone = frame_done_q;
   assign SelErr    = sel_err_q;
endmodule

// File: tb/tb_demux_reg_bank.sv
// Testbench for demux_reg_bank: directed scenarios plus random traffic, checked by a queue-based scoreboard.
module tb_demux_reg_bank;
   logic        clk = 1'b0;
   logic        reset;
   logic [17:0] DatEnt;
   logic        WrEn;
   logic [3:0]  Sel;
   logic        AutoMode;
   logic        Start;
   logic [17:0] Dat0, Dat1, Dat2, Dat3, Dat4, Dat5, Dat6, Dat7, Dat8, Dat9, Dat10;
   logic [3:0]  WrIdx;
   logic        Busy;
   logic        FrameDone;
   logic        SelErr;

   always #5 clk = ~clk;

   demux_reg_bank dut (
      .clk(clk), .reset(reset), .DatEnt(DatEnt), .WrEn(WrEn), .Sel(Sel),
      .AutoMode(AutoMode), .Start(Start),
      .Dat0(Dat0), .Dat1(Dat1), .Dat2(Dat2), .Dat3(Dat3), .Dat4(Dat4), .Dat5(Dat5),
      .Dat6(Dat6), .Dat7(Dat7), .Dat8(Dat8), .Dat9(Dat9), .Dat10(Dat10),
      .WrIdx(WrIdx), .Busy(Busy), .FrameDone(FrameDone), .SelErr(SelErr)
   );

   typedef struct packed {
      logic [31:0]       due;
      logic [10:0][17:0] dat;
      logic [3:0]        idx;
      logic              busy;
      logic              fd;
      logic              se;
   } exp_t;

   exp_t              exp_q[$];
   int                checks = 0;
   int                errors = 0;
   logic [31:0]       cyc = 0;
   logic [10:0][17:0] act_dat;
   bit                am_r = 1'b0;

   // Reference model state: visible registers, shadow copy, fill position.
   logic [10:0][17:0] m_dat;
   logic [10:0][17:0] m_sh;
   int                m_idx;
   bit                m_fill;
   bit                m_fd;
   bit                m_se;

   assign act_dat = {Dat10, Dat9, Dat8, Dat7, Dat6, Dat5, Dat4, Dat3, Dat2, Dat1, Dat0};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void model_step(input bit r, input bit we, input logic [3:0] s,
                                      input bit am, input bit st, input logic [17:0] d);
      if (r) begin
         m_dat = '0; m_sh = '0; m_idx = 0; m_fill = 0; m_fd = 0; m_se = 0;
         return;
      end
      m_fd = 0;
      m_se = 0;
      if (!m_fill) begin
         if (am) begin
            if (st) begin
               m_fill = 1;
               m_idx  = 0;
            end
         end else if (we) begin
            if (int'(s) <= 10) begin
               m_dat[s] = d;
               m_sh[s]  = d;
            end else begin
               m_se = 1;
            end
         end
      end else if (st) begin
         m_idx = 0;
      end else if (we) begin
`ifdef DEMUX_SHADOW_EN
         m_sh[m_idx] = d;
`else
         m_dat[m_idx] = d;
         m_sh[m_idx]  = d;
`endif
         if (m_idx == 10) begin
            m_fill = 0;
            m_idx  = 0;
            m_fd   = 1;
            m_dat  = m_sh;
         end else begin
            m_idx = m_idx + 1;
         end
      end
   endfunction

   task automatic chk(input string nm, input logic [197:0] act, input logic [197:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   task automatic push_expected();
      exp_t e;
      e.due  = cyc + 1;
      e.dat  = m_dat;
      e.idx  = 4'(m_idx);
      e.busy = m_fill;
      e.fd   = m_fd;
      e.se   = m_se;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit r, input bit we, input logic [3:0] s,
                        input bit am, input bit st, input logic [17:0] d);
      @(negedge clk);
      #1;
      reset = r; WrEn = we; Sel = s; AutoMode = am; Start = st; DatEnt = d;
      model_step(r, we, s, am, st, d);
      push_expected();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 18'd0);
   endtask

   // Reset raised between clock edges must clear the outputs without waiting for clk.
   task automatic async_reset();
      @(negedge clk);
      #1;
      reset = 1'b1; WrEn = 1'b0; Start = 1'b0;
      #1;
      chk("async reset Dat bank", 198'(act_dat), 198'(0));
      chk("async reset WrIdx", 198'(WrIdx), 198'(0));
      chk("async reset Busy", 198'(Busy), 198'(0));
      chk("async reset FrameDone", 198'(FrameDone), 198'(0));
      chk("async reset SelErr", 198'(SelErr), 198'(0));
      model_step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 18'd0);
      push_expected();
   endtask

   // Monitor: every cycle, compare the outputs against entries whose edge has passed.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("Dat bank", 198'(act_dat), 198'(e.dat));
            chk("WrIdx", 198'(WrIdx), 198'(e.idx));
            chk("Busy", 198'(Busy), 198'(e.busy));
            chk("FrameDone", 198'(FrameDone), 198'(e.fd));
            chk("SelErr", 198'(SelErr), 198'(e.se));
            $display("txn cyc=%0d WrIdx=%0d Busy=%b FrameDone=%b SelErr=%b Dat0=%h Dat10=%h",
                     cyc, WrIdx, Busy, FrameDone, SelErr, Dat0, Dat10);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach the end of stimulus");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; WrEn = 1'b0; Sel = '0; AutoMode = 1'b0; Start = 1'b0; DatEnt = '0;
      m_dat = '0; m_sh = '0; m_idx = 0; m_fill = 0; m_fd = 0; m_se = 0;

      drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 18'd0);
      drive(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 18'h12345);

      // Manual write, then illegal select
      drive(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 18'h2A5A5);
      idle();
      drive(1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 18'h3FFFF);
      idle();
      idle();

      // Auto fill with WrEn on the Start cycle and AutoMode toggling mid-fill
      drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 18'h3);
      for (int k = 0; k < 11; k++)
         drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'(k & 1), 1'b0, 18'(k + 1));
      idle();
      idle();

      // In IDLE with AutoMode=1, WrEn without Start does nothing
      drive(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 18'h1BEEF);

      // Restart mid-fill
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 18'd0);
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 18'(18'h200 + k));
      drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 18'h3ABCD);
      for (int k = 0; k < 11; k++) drive(1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 18'(18'h100 + k));
      idle();

      // Reset in the middle of a fill, then a manual write on the first edge after release
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 18'd0);
      for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 18'(18'h300 + k));
      async_reset();
      drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 18'h1234);
      idle();

      for (int i = 0; i < 600; i++) begin
         bit r;
         r = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 9) == 0) am_r = ~am_r;
         drive(r, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), am_r,
               ($urandom_range(0, 29) == 0), 18'($urandom));
      end

      idle();
      repeat (3) @(negedge clk);
      #2;
      chk("scoreboard drain", 198'(exp_q.size()), 198'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/demux_reg_bank.md
DEMUX_REG_BANK -- requirements
Module: demux_reg_bank

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk rises-edge clock, reset asynchronous active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 DatEnt  input  18  data word to distribute.
REQ-005 WrEn  input  1  write strobe, qualifies DatEnt for one cycle.
REQ-006 Sel  input  4  destination index for manual mode; legal range 0..10.
REQ-007 AutoMode  input  1  1 = auto-increment fill, 0 = manual addressed write.
REQ-008 Start  input  1  single-cycle pulse that begins an auto fill.
REQ-009 Dat0..Dat10  output  18 each  registered destination words.
REQ-010 WrIdx  output  4  current auto-fill index.
REQ-011 Busy  output  1  high while the FSM is in FILL.
REQ-012 FrameDone  output  1  one-cycle pulse when an auto fill completes.
REQ-013 SelErr  output  1  one-cycle pulse on a manual write with an illegal Sel.

Function
REQ-014 The FSM SHALL have two states: IDLE and FILL.
REQ-015 Manual mode: in IDLE with AutoMode=0 and WrEn=1, Sel 0..10 SHALL load DatEnt into Dat[Sel] at the next rising edge, with 1-cycle latency.
REQ-016 Manual mode: Sel 11..15 with WrEn=1 SHALL write nothing and SHALL pulse SelErr high for exactly the following cycle.
REQ-017 IDLE with AutoMode=1 and Start=1 SHALL move to FILL and set WrIdx=0; WrEn in that same cycle SHALL be ignored.
REQ-018 In FILL, each WrEn=1 cycle SHALL write DatEnt into Dat[WrIdx] and increment WrIdx; Sel SHALL be ignored.
REQ-019 In FILL, the write at WrIdx=10 SHALL return the FSM to IDLE, wrap WrIdx to 0, and pulse FrameDone in the following cycle.
REQ-020 Start=1 while in FILL SHALL restart the fill: WrIdx=0, any WrEn in that cycle ignored, state stays FILL.
REQ-021 AutoMode SHALL be sampled only in IDLE; changing it during FILL SHALL have no effect until the fill completes.
REQ-022 In IDLE with AutoMode=1, WrEn without Start SHALL be ignored.
REQ-023 Busy SHALL equal (state==FILL). Outputs not being written SHALL hold their value.
REQ-024 FrameDone and SelErr SHALL never be asserted for more than one consecutive cycle per triggering event.

Reset
REQ-025 Asserting reset SHALL immediately clear Dat0..Dat10, WrIdx, Busy, FrameDone and SelErr to 0 and force IDLE, including in the middle of a fill.
REQ-026 The first write after reset deassertion SHALL take effect on the first rising edge with reset low.

Configuration
REQ-027 Macro DEMUX_SHADOW_EN defined: auto-fill writes SHALL go to an internal 11x18 shadow bank, and Dat0..Dat10 SHALL all load from the shadow bank on the same edge on which FrameDone rises. Manual writes SHALL update both the output and the shadow entry.
REQ-028 DEMUX_SHADOW_EN undefined: there SHALL be no shadow bank, and auto-fill writes SHALL update Dat[WrIdx] directly as in REQ-018.
REQ-029 With DEMUX_SHADOW_EN defined, reset SHALL also clear the shadow bank, and an aborted or restarted fill SHALL leave Dat0..Dat10 unchanged.

Verification
REQ-030 Manual: reset, AutoMode=0, WrEn with Sel=3 and DatEnt=18'h2A5A5 -> Dat3=18'h2A5A5 one cycle later; all other outputs remain 0.
REQ-031 Illegal select: Sel=12, WrEn=1, DatEnt=18'h3FFFF -> SelErr high for exactly 1 cycle; all Dat outputs unchanged.
REQ-032 Auto fill: Start, then 11 WrEn cycles carrying DatEnt=k+1 for k=0..10 -> DatK=k+1, FrameDone pulses once, Busy falls, WrIdx=0.
REQ-033 Restart: Start, 4 writes, Start, 11 writes of 18'h100+k -> DatK=18'h100+k; exactly one FrameDone pulse.
REQ-034 Reset mid-fill: after 5 auto writes, assert reset -> all outputs 0 asynchronously, state IDLE; a following manual write to Sel=0 works.
REQ-035 With DEMUX_SHADOW_EN defined: during an auto fill, Dat0..Dat10 hold their old values until the FrameDone edge, then all update in the same cycle.
